// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register-file geometry shared by the write arbiter and the register file
package regfile_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 2 ** RF_AW;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ0 = 2'd1,
        GNT_REQ1 = 2'd2
    } gnt_e;

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry write buffer holding address and data for a single requester
module wb_slot
    import regfile_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_drain,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_full,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);

    logic          r_full;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    // A load on the same edge as a drain wins: the slot refills with the new entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester write port arbiter for the register file
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    input  logic              REQ1_VALID,
    output logic              REQ0_READY,
    output logic              REQ1_READY,
    input  logic [AW-1:0]     REQ0_ADDR,
    input  logic [AW-1:0]     REQ1_ADDR,
    input  logic [DW-1:0]     REQ0_DATA,
    input  logic [DW-1:0]     REQ1_DATA,
    output logic              WE3,
    output logic [AW-1:0]     A3,
    output logic [DW-1:0]     WD3,
    output logic [2**AW-1:0]  BUSY
);

    localparam int NREG = 2 ** AW;

    logic            w_full0, w_full1;
    logic [AW-1:0]   w_addr0, w_addr1;
    logic [DW-1:0]   w_data0, w_data1;
    logic            w_load0, w_load1;
    logic            w_gnt0, w_gnt1;
    gnt_e            w_gnt;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [NREG-1:0] w_busy;

    logic            r_ptr;
    logic            r_old1;

    wb_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_load  (w_load0),
        .i_drain (w_gnt0),
        .i_addr  (REQ0_ADDR),
        .i_data  (REQ0_DATA),
        .o_full  (w_full0),
        .o_addr  (w_addr0),
        .o_data  (w_data0)
    );

    wb_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_load  (w_load1),
        .i_drain (w_gnt1),
        .i_addr  (REQ1_ADDR),
        .i_data  (REQ1_DATA),
        .o_full  (w_full1),
        .o_addr  (w_addr1),
        .o_data  (w_data1)
    );

    // Same-address writes must land in arrival order, so age overrides the round-robin pointer.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_full0 && w_full1) begin
            if (w_addr0 == w_addr1) begin
                w_gnt = r_old1 ? GNT_REQ1 : GNT_REQ0;
            end else begin
                w_gnt = r_ptr ? GNT_REQ1 : GNT_REQ0;
            end
        end else if (w_full0) begin
            w_gnt = GNT_REQ0;
        end else if (w_full1) begin
            w_gnt = GNT_REQ1;
        end
    end

    assign w_gnt0 = (w_gnt == GNT_REQ0);
    assign w_gnt1 = (w_gnt == GNT_REQ1);

    assign REQ0_READY = RST_N && (!w_full0 || w_gnt0);
    assign REQ1_READY = RST_N && (!w_full1 || w_gnt1);
    assign w_load0    = REQ0_VALID && REQ0_READY;
    assign w_load1    = REQ1_VALID && REQ1_READY;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        case (w_gnt)
            GNT_REQ0: begin
                w_sel_addr = w_addr0;
                w_sel_data = w_data0;
            end
            GNT_REQ1: begin
                w_sel_addr = w_addr1;
                w_sel_data = w_data1;
            end
            default: begin
                w_sel_addr = '0;
                w_sel_data = '0;
            end
        endcase
    end

    assign WE3 = (w_gnt != GNT_NONE) && !(DISCARD_R0 && (w_sel_addr == '0));
    assign A3  = w_sel_addr;
    assign WD3 = w_sel_data;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NREG; i++) begin
            w_busy[i] = (w_full0 && (w_addr0 == AW'(i))) || (w_full1 && (w_addr1 == AW'(i)));
        end
        if (DISCARD_R0) begin
            w_busy[0] = 1'b0;
        end
    end

    assign BUSY = w_busy;

    // r_old1 is set when slot 1 holds the older entry; a fresh load is always the youngest.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr  <= 1'b0;
            r_old1 <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_ptr <= 1'b0;
            end
            if (w_load1) begin
                r_old1 <= 1'b0;
            end else if (w_load0) begin
                r_old1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        REQ0_VALID, REQ1_VALID;
    logic        REQ0_READY, REQ1_READY;
    logic [4:0]  REQ0_ADDR, REQ1_ADDR;
    logic [31:0] REQ0_DATA, REQ1_DATA;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] BUSY;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_write_arbiter dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ0_VALID (REQ0_VALID),
        .REQ1_VALID (REQ1_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ1_READY (REQ1_READY),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ0_DATA  (REQ0_DATA),
        .REQ1_DATA  (REQ1_DATA),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .BUSY       (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        r0;
        logic        r1;
        logic [31:0] busy;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        REQ0_ADDR  = '0;
        REQ1_ADDR  = '0;
        REQ0_DATA  = '0;
        REQ1_DATA  = '0;
    endtask

    logic [31:0] exp0[$], exp1[$], got0[$], got1[$];
    int n0, n1, got_other;

    initial begin
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h20};
        vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220002, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220002, 1'b1, 5'd1, 32'h11110001, 1'b1, 1'b0, 32'h6};
        vt[7]  = '{1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220002, 1'b1, 5'd2, 32'h22220002, 1'b0, 1'b1, 32'h6};
        vt[8]  = '{1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220002, 1'b1, 5'd1, 32'h11110001, 1'b1, 1'b0, 32'h6};
        vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 32'h22220002, 1'b0, 1'b1, 32'h6};
        vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 32'h11110001, 1'b1, 1'b1, 32'h2};
        vt[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[12] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11,       1'b1, 1'b0, 32'h80};
        vt[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h22,       1'b1, 1'b1, 32'h80};
        vt[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[16] = '{1'b1, 5'd3, 32'h31,       1'b1, 5'd4, 32'h41,       1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[17] = '{1'b1, 5'd4, 32'h42,       1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h31,       1'b1, 1'b0, 32'h18};
        vt[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h41,       1'b0, 1'b1, 32'h10};
        vt[19] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h42,       1'b1, 1'b1, 32'h10};
        vt[20] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h0};

        RST_N = 1'b0;
        idle_inputs();
        #2;
        check("reset.we",   {31'b0, WE3}, 32'h0);
        check("reset.rdy0", {31'b0, REQ0_READY}, 32'h0);
        check("reset.rdy1", {31'b0, REQ1_READY}, 32'h0);
        check("reset.busy", BUSY, 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        for (int k = 0; k < NV; k++) begin
            REQ0_VALID = vt[k].v0;
            REQ0_ADDR  = vt[k].a0;
            REQ0_DATA  = vt[k].d0;
            REQ1_VALID = vt[k].v1;
            REQ1_ADDR  = vt[k].a1;
            REQ1_DATA  = vt[k].d1;
            @(negedge CLK);
            check($sformatf("v%0d.we", k),   {31'b0, WE3}, {31'b0, vt[k].we});
            check($sformatf("v%0d.a3", k),   {27'b0, A3},  {27'b0, vt[k].a3});
            check($sformatf("v%0d.wd3", k),  WD3,          vt[k].wd);
            check($sformatf("v%0d.rdy0", k), {31'b0, REQ0_READY}, {31'b0, vt[k].r0});
            check($sformatf("v%0d.rdy1", k), {31'b0, REQ1_READY}, {31'b0, vt[k].r1});
            check($sformatf("v%0d.busy", k), BUSY,         vt[k].busy);
            @(posedge CLK);
            #1;
        end

        // Reset asserted mid-cycle with both slots full.
        REQ0_VALID = 1'b1; REQ0_ADDR = 5'd10; REQ0_DATA = 32'hAAAA0000;
        REQ1_VALID = 1'b1; REQ1_ADDR = 5'd11; REQ1_DATA = 32'hBBBB0000;
        @(posedge CLK);
        #1 idle_inputs();
        #1;
        check("rst_mid.pre_we",   {31'b0, WE3}, 32'h1);
        check("rst_mid.pre_busy", BUSY, 32'h00000C00);
        RST_N = 1'b0;
        #1;
        check("rst_mid.we",   {31'b0, WE3}, 32'h0);
        check("rst_mid.a3",   {27'b0, A3}, 32'h0);
        check("rst_mid.wd3",  WD3, 32'h0);
        check("rst_mid.rdy0", {31'b0, REQ0_READY}, 32'h0);
        check("rst_mid.rdy1", {31'b0, REQ1_READY}, 32'h0);
        check("rst_mid.busy", BUSY, 32'h0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_rel.rdy0", {31'b0, REQ0_READY}, 32'h1);
        check("rst_rel.rdy1", {31'b0, REQ1_READY}, 32'h1);
        check("rst_rel.we",   {31'b0, WE3}, 32'h0);
        check("rst_rel.busy", BUSY, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        check("rst_rel.we2",  {31'b0, WE3}, 32'h0);
        @(posedge CLK);
        #1;

        // Back-pressure: REQ0 holds addr 3 for 4 cycles against a streaming REQ1.
        n0 = 0; n1 = 0; got_other = 0;
        for (int c = 0; c < 12; c++) begin
            REQ0_VALID = (c < 4);
            REQ0_ADDR  = 5'd3;
            REQ0_DATA  = 32'h30000000 + 32'(n0);
            REQ1_VALID = (c < 6);
            REQ1_ADDR  = 5'd8;
            REQ1_DATA  = 32'h80000000 + 32'(n1);
            @(negedge CLK);
            if (WE3) begin
                if (A3 == 5'd3)      got0.push_back(WD3);
                else if (A3 == 5'd8) got1.push_back(WD3);
                else                 got_other++;
            end
            if (REQ0_VALID && REQ0_READY) begin
                exp0.push_back(REQ0_DATA);
                n0++;
            end
            if (REQ1_VALID && REQ1_READY) begin
                exp1.push_back(REQ1_DATA);
                n1++;
            end
            @(posedge CLK);
            #1;
        end
        check("bp.req0_accepts", 32'(n0), 32'd3);
        check("bp.req1_accepts", 32'(n1), 32'd3);
        check("bp.req0_writes",  32'(got0.size()), 32'(exp0.size()));
        check("bp.req1_writes",  32'(got1.size()), 32'(exp1.size()));
        check("bp.stray_writes", 32'(got_other), 32'd0);
        for (int i = 0; i < exp0.size(); i++) begin
            if (i < got0.size()) check($sformatf("bp.req0_data%0d", i), got0[i], exp0[i]);
        end
        for (int i = 0; i < exp1.size(); i++) begin
            if (i < got1.size()) check($sformatf("bp.req1_data%0d", i), got1[i], exp1[i]);
        end
        idle_inputs();
        @(negedge CLK);
        check("bp.final_we",   {31'b0, WE3}, 32'h0);
        check("bp.final_busy", BUSY, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
